// File: rtl/shared_buffer_credit_tracker_if.sv
// Bundle of the send/credit event inputs and allocator-facing status outputs
// of shared_buffer_credit_tracker. The master side drives the events (crossbar
// and downstream credit return); the slave side is the tracker itself.
interface shared_buffer_credit_tracker_if #(
    parameter int MAX_VC_NUMBER     = 10,
    parameter int MEMORY_BANK_DEPTH = 32
);
    localparam int CNT_W = $clog2(MEMORY_BANK_DEPTH + 1);

    logic                       i_flit_sent;
    logic [0:MAX_VC_NUMBER-1]   i_vc_sent_on;
    logic                       i_credit_valid;
    logic [0:MAX_VC_NUMBER-1]   i_credit_vc;
    logic [0:MAX_VC_NUMBER-1]   o_vc_credit_avail;
    logic [0:MAX_VC_NUMBER-1]   o_vc_empty;
    logic [CNT_W-1:0]           o_shared_free_count;
    logic                       o_bank_full;
    logic                       o_bank_empty;
    logic                       o_error_overflow;
    logic                       o_error_underflow;

    modport master (
        output i_flit_sent, i_vc_sent_on, i_credit_valid, i_credit_vc,
        input  o_vc_credit_avail, o_vc_empty, o_shared_free_count,
               o_bank_full, o_bank_empty, o_error_overflow, o_error_underflow
    );

    modport slave (
        input  i_flit_sent, i_vc_sent_on, i_credit_valid, i_credit_vc,
        output o_vc_credit_avail, o_vc_empty, o_shared_free_count,
               o_bank_full, o_bank_empty, o_error_overflow, o_error_underflow
    );
endinterface

// File: rtl/shared_buffer_credit_tracker.sv
// Upstream mirror of a downstream dynamically-shared input buffer. Each VC
// owns RESERVED_PER_VC private slots; everything beyond that comes out of a
// shared pool. Per-VC occupancy, shared-pool usage and total occupancy are
// tracked, and every status output is registered from the next-state values
// so it reflects the state right after the edge that sampled an event.
module shared_buffer_credit_tracker #(
    parameter int MAX_VC_NUMBER     = 10,
    parameter int MEMORY_BANK_DEPTH = 32,
    parameter int RESERVED_PER_VC   = 1,
    parameter int MAX_VC_DEPTH      = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    shared_buffer_credit_tracker_if.slave bus
);
    localparam int SHARED_SIZE = MEMORY_BANK_DEPTH - MAX_VC_NUMBER * RESERVED_PER_VC;
    localparam int OCC_W       = $clog2(MAX_VC_DEPTH + 1);
    localparam int CNT_W       = $clog2(MEMORY_BANK_DEPTH + 1);

    localparam logic [OCC_W-1:0] C_OCC_CAP  = OCC_W'(MAX_VC_DEPTH);
    localparam logic [OCC_W-1:0] C_OCC_RES  = OCC_W'(RESERVED_PER_VC);
    localparam logic [OCC_W-1:0] C_OCC_ZERO = {OCC_W{1'b0}};
    localparam logic [OCC_W-1:0] C_OCC_ONE  = {{(OCC_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] C_CNT_SHR  = CNT_W'(SHARED_SIZE);
    localparam logic [CNT_W-1:0] C_CNT_DEP  = CNT_W'(MEMORY_BANK_DEPTH);
    localparam logic [CNT_W-1:0] C_CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] C_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef logic [0:MAX_VC_NUMBER-1] vc_vec_t;
    localparam vc_vec_t C_VC_NONE = {MAX_VC_NUMBER{1'b0}};

    // A VC may send when under its cap and either inside its reservation or
    // the shared pool still has room.
    function automatic logic f_avail(input logic [OCC_W-1:0] occ,
                                     input logic [CNT_W-1:0] shared_used);
        return (occ < C_OCC_CAP) && ((occ < C_OCC_RES) || (shared_used < C_CNT_SHR));
    endfunction

    function automatic logic f_onehot(input vc_vec_t vec);
        return $onehot(vec);
    endfunction

    logic [OCC_W-1:0] r_occ [MAX_VC_NUMBER];
    logic [CNT_W-1:0] r_shared_used;
    logic [CNT_W-1:0] r_total;
    logic             r_err_overflow;
    logic             r_err_underflow;
    vc_vec_t          r_avail;
    vc_vec_t          r_vc_empty;
    logic [CNT_W-1:0] r_shared_free;
    logic             r_bank_full;
    logic             r_bank_empty;

    logic             w_send_ok;
    logic             w_cred_ok;
    logic             w_send_bad;
    logic             w_cred_bad;
    logic             w_shared_inc;
    logic             w_shared_dec;
    logic [OCC_W-1:0] w_occ_nxt [MAX_VC_NUMBER];
    logic [CNT_W-1:0] w_shared_nxt;
    logic [CNT_W-1:0] w_total_nxt;

    // Judge both events against pre-cycle state and derive next-state counts.
    always_comb begin
        w_send_ok    = 1'b0;
        w_cred_ok    = 1'b0;
        w_shared_inc = 1'b0;
        w_shared_dec = 1'b0;
        w_total_nxt  = r_total;

        if (bus.i_flit_sent && f_onehot(bus.i_vc_sent_on) &&
            ((bus.i_vc_sent_on & r_avail) != C_VC_NONE)) begin
            w_send_ok = 1'b1;
        end else begin
            w_send_ok = 1'b0;
        end

        if (bus.i_credit_valid && f_onehot(bus.i_credit_vc) &&
            ((bus.i_credit_vc & ~r_vc_empty) != C_VC_NONE)) begin
            w_cred_ok = 1'b1;
        end else begin
            w_cred_ok = 1'b0;
        end

        w_send_bad = bus.i_flit_sent    && !w_send_ok;
        w_cred_bad = bus.i_credit_valid && !w_cred_ok;

        // A send and credit on the same VC cancel, including the shared pool:
        // the slot freed and the slot taken are the same one.
        for (int v = 0; v < MAX_VC_NUMBER; v++) begin
            w_occ_nxt[v] = r_occ[v];
            if (w_send_ok && bus.i_vc_sent_on[v] && w_cred_ok && bus.i_credit_vc[v]) begin
                w_occ_nxt[v] = r_occ[v];
            end else if (w_send_ok && bus.i_vc_sent_on[v]) begin
                w_occ_nxt[v] = r_occ[v] + C_OCC_ONE;
                if (r_occ[v] >= C_OCC_RES) begin
                    w_shared_inc = 1'b1;
                end else begin
                    w_shared_inc = w_shared_inc;
                end
            end else if (w_cred_ok && bus.i_credit_vc[v]) begin
                w_occ_nxt[v] = r_occ[v] - C_OCC_ONE;
                if (r_occ[v] > C_OCC_RES) begin
                    w_shared_dec = 1'b1;
                end else begin
                    w_shared_dec = w_shared_dec;
                end
            end else begin
                w_occ_nxt[v] = r_occ[v];
            end
        end

        w_shared_nxt = r_shared_used + {{(CNT_W-1){1'b0}}, w_shared_inc}
                                     - {{(CNT_W-1){1'b0}}, w_shared_dec};

        case ({w_send_ok, w_cred_ok})
            2'b10:   w_total_nxt = r_total + C_CNT_ONE;
            2'b01:   w_total_nxt = r_total - C_CNT_ONE;
            default: w_total_nxt = r_total;
        endcase
    end

    // Occupancy counters and sticky error flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int v = 0; v < MAX_VC_NUMBER; v++) begin
                r_occ[v] <= C_OCC_ZERO;
            end
            r_shared_used   <= C_CNT_ZERO;
            r_total         <= C_CNT_ZERO;
            r_err_overflow  <= 1'b0;
            r_err_underflow <= 1'b0;
        end else begin
            for (int v = 0; v < MAX_VC_NUMBER; v++) begin
                r_occ[v] <= w_occ_nxt[v];
            end
            r_shared_used   <= w_shared_nxt;
            r_total         <= w_total_nxt;
            r_err_overflow  <= r_err_overflow  | w_send_bad;
            r_err_underflow <= r_err_underflow | w_cred_bad;
        end
    end

    // Status outputs registered from next-state so they match the counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int v = 0; v < MAX_VC_NUMBER; v++) begin
                r_avail[v]    <= f_avail(C_OCC_ZERO, C_CNT_ZERO);
                r_vc_empty[v] <= 1'b1;
            end
            r_shared_free <= C_CNT_SHR;
            r_bank_full   <= 1'b0;
            r_bank_empty  <= 1'b1;
        end else begin
            for (int v = 0; v < MAX_VC_NUMBER; v++) begin
                r_avail[v]    <= f_avail(w_occ_nxt[v], w_shared_nxt);
                r_vc_empty[v] <= (w_occ_nxt[v] == C_OCC_ZERO);
            end
            r_shared_free <= C_CNT_SHR - w_shared_nxt;
            r_bank_full   <= (w_total_nxt == C_CNT_DEP);
            r_bank_empty  <= (w_total_nxt == C_CNT_ZERO);
        end
    end

    assign bus.o_vc_credit_avail   = r_avail;
    assign bus.o_vc_empty          = r_vc_empty;
    assign bus.o_shared_free_count = r_shared_free;
    assign bus.o_bank_full         = r_bank_full;
    assign bus.o_bank_empty        = r_bank_empty;
    assign bus.o_error_overflow    = r_err_overflow;
    assign bus.o_error_underflow   = r_err_underflow;

endmodule

// File: tb/tb_shared_buffer_credit_tracker.sv
// Bench for shared_buffer_credit_tracker: directed scenarios followed by
// randomized traffic, all outputs compared each cycle against a model that
// keeps only per-VC occupancy and derives everything else from it.
module tb_shared_buffer_credit_tracker;
    localparam int N   = 10;
    localparam int D   = 32;
    localparam int R   = 1;
    localparam int CAP = 8;
    localparam int SH  = D - N * R;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    shared_buffer_credit_tracker_if #(.MAX_VC_NUMBER(N), .MEMORY_BANK_DEPTH(D)) bus ();

    shared_buffer_credit_tracker #(
        .MAX_VC_NUMBER(N), .MEMORY_BANK_DEPTH(D),
        .RESERVED_PER_VC(R), .MAX_VC_DEPTH(CAP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int occ [N];
    bit m_ovf;
    bit m_udf;
    int checks   = 0;
    int failures = 0;

    // Shared usage is whatever each VC holds beyond its reservation.
    function automatic int m_shared();
        int s = 0;
        for (int v = 0; v < N; v++) if (occ[v] > R) s += occ[v] - R;
        return s;
    endfunction

    function automatic int m_total();
        int s = 0;
        for (int v = 0; v < N; v++) s += occ[v];
        return s;
    endfunction

    function automatic bit m_avail(int v);
        return (occ[v] < CAP) && (occ[v] < R || m_shared() < SH);
    endfunction

    function automatic int oh_idx(logic [0:N-1] vec);
        int idx = -1;
        int cnt = 0;
        for (int v = 0; v < N; v++) if (vec[v] === 1'b1) begin cnt++; idx = v; end
        return (cnt == 1) ? idx : -1;
    endfunction

    function automatic logic [0:N-1] oh(int v);
        logic [0:N-1] r;
        r = '0;
        r[v] = 1'b1;
        return r;
    endfunction

    task automatic model_step(bit rst, bit fs, logic [0:N-1] sv, bit cvld, logic [0:N-1] cv);
        int si = -1;
        int ci = -1;
        if (rst) begin
            for (int v = 0; v < N; v++) occ[v] = 0;
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            if (fs) begin
                si = oh_idx(sv);
                if (si < 0 || !m_avail(si)) begin m_ovf = 1'b1; si = -1; end
            end
            if (cvld) begin
                ci = oh_idx(cv);
                if (ci < 0 || occ[ci] == 0) begin m_udf = 1'b1; ci = -1; end
            end
            if (si >= 0) occ[si]++;
            if (ci >= 0) occ[ci]--;
        end
    endtask

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic [0:N-1] e_avail;
        logic [0:N-1] e_empty;
        for (int v = 0; v < N; v++) begin
            e_avail[v] = m_avail(v);
            e_empty[v] = (occ[v] == 0);
        end
        chk("vc_credit_avail",   64'(bus.o_vc_credit_avail),   64'(e_avail));
        chk("vc_empty",          64'(bus.o_vc_empty),          64'(e_empty));
        chk("shared_free_count", 64'(bus.o_shared_free_count), 64'(SH - m_shared()));
        chk("bank_full",         64'(bus.o_bank_full),         64'(m_total() == D));
        chk("bank_empty",        64'(bus.o_bank_empty),        64'(m_total() == 0));
        chk("error_overflow",    64'(bus.o_error_overflow),    64'(m_ovf));
        chk("error_underflow",   64'(bus.o_error_underflow),   64'(m_udf));
    endtask

    task automatic step(bit rst, bit fs, logic [0:N-1] sv, bit cvld, logic [0:N-1] cv);
        reset              = rst;
        bus.i_flit_sent    = fs;
        bus.i_vc_sent_on   = sv;
        bus.i_credit_valid = cvld;
        bus.i_credit_vc    = cv;
        model_step(rst, fs, sv, cvld, cv);
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic send(int v);
        step(1'b0, 1'b1, oh(v), 1'b0, '0);
    endtask

    initial begin
        logic [0:N-1] lit;
        logic [0:N-1] zero_vec;
        logic [0:N-1] sv;
        logic [0:N-1] cv;
        bit fs;
        bit cvld;
        int send_pct;
        int cred_pct;
        int nz [$];

        zero_vec = '0;
        for (int v = 0; v < N; v++) occ[v] = 0;
        m_ovf = 1'b0;
        m_udf = 1'b0;

        // Reset and defaults.
        step(1'b1, 1'b0, zero_vec, 1'b0, zero_vec);
        step(1'b0, 1'b0, zero_vec, 1'b0, zero_vec);
        lit = 10'b1111111111;
        chk("lit_reset_avail", 64'(bus.o_vc_credit_avail), 64'(lit));
        chk("lit_reset_free", 64'(bus.o_shared_free_count), 64'd22);
        chk("lit_reset_bank_empty", 64'(bus.o_bank_empty), 64'd1);

        // Eight sends on VC0 up to its cap.
        send(0);
        chk("lit_bank_empty_after_send", 64'(bus.o_bank_empty), 64'd0);
        for (int i = 1; i < 8; i++) send(0);
        lit = 10'b0111111111;
        chk("lit_vc0_cap_avail", 64'(bus.o_vc_credit_avail), 64'(lit));
        chk("lit_vc0_cap_free", 64'(bus.o_shared_free_count), 64'd15);
        send(0);
        chk("lit_send_past_cap_ovf", 64'(bus.o_error_overflow), 64'd1);
        step(1'b1, 1'b0, zero_vec, 1'b0, zero_vec);
        for (int i = 0; i < 8; i++) send(0);

        // Exhaust the shared pool, then the reservations.
        for (int i = 0; i < 8; i++) send(1);
        for (int i = 0; i < 8; i++) send(2);
        send(3);
        send(3);
        lit = 10'b0000111111;
        chk("lit_pool_empty_avail", 64'(bus.o_vc_credit_avail), 64'(lit));
        chk("lit_pool_empty_free", 64'(bus.o_shared_free_count), 64'd0);
        for (int v = 4; v < N; v++) send(v);
        chk("lit_full_bank_full", 64'(bus.o_bank_full), 64'd1);
        chk("lit_full_avail", 64'(bus.o_vc_credit_avail), 64'd0);

        // Illegal send plus credit, then same-VC send+credit.
        step(1'b0, 1'b1, oh(3), 1'b1, oh(0));
        chk("lit_full_ovf", 64'(bus.o_error_overflow), 64'd1);
        chk("lit_credit_free", 64'(bus.o_shared_free_count), 64'd1);
        step(1'b0, 1'b1, oh(3), 1'b1, oh(3));
        chk("lit_same_vc_free", 64'(bus.o_shared_free_count), 64'd1);

        // Underflow on an empty VC, two-hot send.
        step(1'b0, 1'b0, zero_vec, 1'b1, oh(9));
        step(1'b0, 1'b0, zero_vec, 1'b1, oh(9));
        chk("lit_underflow", 64'(bus.o_error_underflow), 64'd1);
        lit = 10'b0000110000;
        step(1'b0, 1'b1, lit, 1'b0, zero_vec);
        chk("lit_two_hot_ovf", 64'(bus.o_error_overflow), 64'd1);

        // Reset mid-traffic with a concurrent send.
        step(1'b1, 1'b1, oh(1), 1'b0, zero_vec);
        chk("lit_rst_free", 64'(bus.o_shared_free_count), 64'd22);
        chk("lit_rst_ovf", 64'(bus.o_error_overflow), 64'd0);
        chk("lit_rst_empty", 64'(bus.o_vc_empty), 64'h3ff);

        // Randomized traffic in fill/drain phases.
        for (int i = 0; i < 4000; i++) begin
            if (((i / 150) % 2) == 0) begin send_pct = 85; cred_pct = 35; end
            else begin send_pct = 30; cred_pct = 85; end
            fs = ($urandom_range(99) < send_pct);
            if ($urandom_range(15) == 0) sv = N'($urandom);
            else sv = oh($urandom_range(N - 1));
            cvld = ($urandom_range(99) < cred_pct);
            nz.delete();
            for (int v = 0; v < N; v++) if (occ[v] > 0) nz.push_back(v);
            if ($urandom_range(15) == 0) cv = N'($urandom);
            else if (nz.size() > 0 && $urandom_range(9) != 0)
                cv = oh(nz[$urandom_range(nz.size() - 1)]);
            else cv = oh($urandom_range(N - 1));
            step(($urandom_range(399) == 0), fs, sv, cvld, cv);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
